// File: rtl/counter_multimode.sv
// Multi-mode up/down counter (binary, gray, ring, johnson, BCD) with programmable limit,
// wrap/saturate, registered terminal count and illegal-code flag. Optional macro: COUNTER_SELF_CORRECT_EN.
module counter_multimode #(
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   count_dir,
    input  logic                   count_enable_,
    input  logic [2:0]             count_type,
    input  logic                   load_,
    input  logic [COUNT_WIDTH-1:0] load_val,
    input  logic [COUNT_WIDTH-1:0] limit,
    input  logic                   wrap_mode,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   tc,
    output logic                   illegal,
    output logic [2:0]             mode
);
    localparam int W    = COUNT_WIDTH;
    localparam int NDIG = COUNT_WIDTH / 4;

    localparam logic [2:0] MODE_BIN     = 3'd0;
    localparam logic [2:0] MODE_GRAY    = 3'd1;
    localparam logic [2:0] MODE_RING    = 3'd2;
    localparam logic [2:0] MODE_JOHNSON = 3'd3;
    localparam logic [2:0] MODE_BCD     = 3'd4;

    localparam logic [W-1:0] ZERO     = '0;
    localparam logic [W-1:0] ALL_ONES = '1;
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MSB_HOT  = {1'b1, {(W-1){1'b0}}};

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Digits above 9 are read as 9 when counting up.
    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int d = 0; d < NDIG; d++) begin
            if (v[4*d +: 4] > 4'd9) r[4*d +: 4] = 4'd9;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (carry) begin
                if (v[4*d +: 4] >= 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (borrow) begin
                if (v[4*d +: 4] == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic bcd_bad(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int d = 0; d < NDIG; d++) begin
            if (v[4*d +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic is_onehot(input logic [W-1:0] v);
        return (v != ZERO) && ((v & (v - ONE)) == ZERO);
    endfunction

    // Legal johnson codes are a run of ones at either end: 0..01..1 or 1..10..0.
    function automatic logic is_johnson(input logic [W-1:0] v);
        return ((v & (v + ONE)) == ZERO) || ((~v & (~v + ONE)) == ZERO);
    endfunction

    logic [W-1:0] r_count;
    logic [W-1:0] r_limit;
    logic [2:0]   r_mode;
    logic         r_wrap;
    logic         r_tc;

    logic [W-1:0] w_bin;
    logic [W-1:0] w_step;
    logic [W-1:0] w_wrap_val;
    logic [W-1:0] w_next;
    logic         w_at_end;
    logic         w_rotating;
    logic         w_illegal;
    logic         w_tc_next;

    assign w_bin = gray2bin(r_count);

    always_comb begin
        w_at_end   = 1'b0;
        w_step     = r_count;
        w_wrap_val = ZERO;
        w_rotating = 1'b0;
        w_illegal  = 1'b0;
        case (r_mode)
            MODE_GRAY: begin
                w_at_end   = count_dir ? (w_bin == ALL_ONES) : (w_bin == ZERO);
                w_step     = bin2gray(count_dir ? (w_bin + ONE) : (w_bin - ONE));
                w_wrap_val = count_dir ? ZERO : bin2gray(ALL_ONES);
            end
            MODE_RING: begin
                w_rotating = 1'b1;
                w_illegal  = !is_onehot(r_count);
                if (count_dir) begin
                    w_at_end = (r_count == ONE);
                    w_step   = {r_count[0], r_count[W-1:1]};
                end else begin
                    w_at_end = (r_count == MSB_HOT);
                    w_step   = {r_count[W-2:0], r_count[W-1]};
                end
            end
            MODE_JOHNSON: begin
                w_rotating = 1'b1;
                w_illegal  = !is_johnson(r_count);
                if (count_dir) begin
                    w_at_end = (r_count == ONE);
                    w_step   = {~r_count[0], r_count[W-1:1]};
                end else begin
                    w_at_end = (r_count == MSB_HOT);
                    w_step   = {r_count[W-2:0], ~r_count[W-1]};
                end
            end
            MODE_BCD: begin
                w_illegal  = bcd_bad(r_count);
                w_at_end   = count_dir ? (bcd_clamp(r_count) >= r_limit) : (r_count == ZERO);
                w_step     = count_dir ? bcd_inc(bcd_clamp(r_count)) : bcd_dec(r_count);
                w_wrap_val = count_dir ? ZERO : r_limit;
            end
            default: begin
                // Binary and the reserved codes; a count above the limit counts as the up endpoint.
                w_at_end   = count_dir ? (r_count >= r_limit) : (r_count == ZERO);
                w_step     = count_dir ? (r_count + ONE) : (r_count - ONE);
                w_wrap_val = count_dir ? ZERO : r_limit;
            end
        endcase
    end

    always_comb begin
        w_next    = r_count;
        w_tc_next = 1'b0;
`ifdef COUNTER_SELF_CORRECT_EN
        if (w_illegal) begin
            w_next = (r_mode == MODE_RING) ? ONE : ZERO;
        end else
`endif
        if (w_rotating) begin
            w_next    = w_step;
            w_tc_next = w_at_end;
        end else if (w_at_end) begin
            w_next    = r_wrap ? r_count : w_wrap_val;
            w_tc_next = 1'b1;
        end else begin
            w_next = w_step;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= ZERO;
            r_mode  <= MODE_BIN;
            r_limit <= ALL_ONES;
            r_wrap  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (!load_) begin
            r_count <= load_val;
            r_mode  <= count_type;
            r_limit <= limit;
            r_wrap  <= wrap_mode;
            r_tc    <= 1'b0;
        end else if (!count_enable_) begin
            r_count <= w_next;
            r_tc    <= w_tc_next;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign mode    = r_mode;
    assign illegal = w_illegal;

endmodule

// File: tb/tb_counter_multimode.sv
// Scoreboard bench for counter_multimode: an 8-bit and a 4-bit instance driven in parallel,
// expected results from an arithmetic reference model queued per cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_counter_multimode;

    typedef struct packed {
        logic       rst;
        logic       ld_n;
        logic       en_n;
        logic       dir;
        logic [2:0] typ;
        logic [7:0] lv;
        logic [7:0] lim;
        logic       wr;
    } stim_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       tc;
        logic [2:0] mode;
        logic       ill;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0 = 1'b1, ld0_n = 1'b1, en0_n = 1'b1, dir0 = 1'b0, wr0 = 1'b0;
    logic [2:0] typ0 = 3'd0;
    logic [7:0] lv0 = 8'd0, lim0 = 8'd0;
    logic [7:0] cnt0;
    logic       tc0, ill0;
    logic [2:0] mode0;

    logic       rst1 = 1'b1, ld1_n = 1'b1, en1_n = 1'b1, dir1 = 1'b0, wr1 = 1'b0;
    logic [2:0] typ1 = 3'd0;
    logic [3:0] lv1 = 4'd0, lim1 = 4'd0;
    logic [3:0] cnt1;
    logic       tc1, ill1;
    logic [2:0] mode1;

    counter_multimode #(.COUNT_WIDTH(8)) dut8 (
        .clk(clk), .reset(rst0), .count_dir(dir0), .count_enable_(en0_n), .count_type(typ0),
        .load_(ld0_n), .load_val(lv0), .limit(lim0), .wrap_mode(wr0),
        .count(cnt0), .tc(tc0), .illegal(ill0), .mode(mode0)
    );

    counter_multimode #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset(rst1), .count_dir(dir1), .count_enable_(en1_n), .count_type(typ1),
        .load_(ld1_n), .load_val(lv1), .limit(lim1), .wrap_mode(wr1),
        .count(cnt1), .tc(tc1), .illegal(ill1), .mode(mode1)
    );

    // ---------------- reference model ----------------
    int mc[2];
    int mm[2];
    int ml[2];
    bit mw[2];
    int wd[2] = '{8, 4};

    function automatic int msk(input int w);
        return (1 << w) - 1;
    endfunction

    function automatic int g2b(input int g, input int w);
        int b = 0;
        for (int k = 0; k < w; k++) b = b ^ (g >> k);
        return b;
    endfunction

    function automatic bit john_legal(input int c, input int w);
        for (int k = 0; k <= w; k++) begin
            if (c == ((msk(w) << (w - k)) & msk(w))) return 1'b1;
            if (c == msk(k)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit bcd_legal(input int c, input int w);
        for (int d = 0; d < w / 4; d++) if (((c >> (4 * d)) & 15) > 9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_value(input int c, input int w);
        int v = 0;
        int p = 1;
        int dig;
        for (int d = 0; d < w / 4; d++) begin
            dig = (c >> (4 * d)) & 15;
            if (dig > 9) dig = 9;
            v = v + dig * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic int to_bcd(input int v, input int w);
        int r = 0;
        int x = v;
        for (int d = 0; d < w / 4; d++) begin
            r = r | ((x % 10) << (4 * d));
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int bcd_down(input int c, input int w);
        int fill = 0;
        for (int d = 0; d < w / 4; d++) begin
            if (((c >> (4 * d)) & 15) != 0) return (c - (1 << (4 * d))) | fill;
            fill = fill | (9 << (4 * d));
        end
        return c;
    endfunction

    function automatic bit m_illegal(input int c, input int m, input int w);
        case (m)
            2:       return $countones(c) != 1;
            3:       return !john_legal(c, w);
            4:       return !bcd_legal(c, w);
            default: return 1'b0;
        endcase
    endfunction

    task automatic model(input int i, input stim_t s, output exp_t e);
        int w, full, c, b;
        bit t;
        w    = wd[i];
        full = msk(w);
        t    = 1'b0;
        if (s.rst) begin
            mc[i] = 0; mm[i] = 0; ml[i] = full; mw[i] = 1'b0;
        end else if (!s.ld_n) begin
            mc[i] = int'(s.lv) & full; mm[i] = int'(s.typ); ml[i] = int'(s.lim) & full; mw[i] = s.wr;
        end else if (!s.en_n) begin
            c = mc[i];
`ifdef COUNTER_SELF_CORRECT_EN
            if (m_illegal(c, mm[i], w)) c = (mm[i] == 2) ? 1 : 0;
            else
`endif
            begin
                case (mm[i])
                    1: begin
                        b = g2b(c, w);
                        if (s.dir) begin t = (b == full); b = t ? (mw[i] ? b : 0) : b + 1; end
                        else begin t = (b == 0); b = t ? (mw[i] ? b : full) : b - 1; end
                        c = b ^ (b >> 1);
                    end
                    2: begin
                        if (s.dir) begin t = (c == 1); c = (c >> 1) | ((c & 1) << (w - 1)); end
                        else begin t = (c == (1 << (w - 1))); c = ((c << 1) & full) | (c >> (w - 1)); end
                    end
                    3: begin
                        if (s.dir) begin t = (c == 1); c = (c >> 1) | (((~c) & 1) << (w - 1)); end
                        else begin t = (c == (1 << (w - 1))); c = ((c << 1) & full) | (((~c) >> (w - 1)) & 1); end
                    end
                    4: begin
                        if (s.dir) begin
                            t = bcd_value(c, w) >= bcd_value(ml[i], w);
                            c = t ? (mw[i] ? c : 0) : to_bcd(bcd_value(c, w) + 1, w);
                        end else begin
                            t = (c == 0);
                            c = t ? (mw[i] ? c : ml[i]) : bcd_down(c, w);
                        end
                    end
                    default: begin
                        if (s.dir) begin t = (c >= ml[i]); c = t ? (mw[i] ? c : 0) : c + 1; end
                        else begin t = (c == 0); c = t ? (mw[i] ? c : ml[i]) : c - 1; end
                    end
                endcase
            end
            mc[i] = c & full;
        end
        e.cnt  = 8'(mc[i]);
        e.tc   = t;
        e.mode = 3'(mm[i]);
        e.ill  = m_illegal(mc[i], mm[i], w);
    endtask

    // ---------------- scoreboard ----------------
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("w8.count", cnt0, e.cnt);
                chk("w8.tc", {7'd0, tc0}, {7'd0, e.tc});
                chk("w8.mode", {5'd0, mode0}, {5'd0, e.mode});
                chk("w8.illegal", {7'd0, ill0}, {7'd0, e.ill});
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("w4.count", {4'd0, cnt1}, e.cnt);
                chk("w4.tc", {7'd0, tc1}, {7'd0, e.tc});
                chk("w4.mode", {5'd0, mode1}, {5'd0, e.mode});
                chk("w4.illegal", {7'd0, ill1}, {7'd0, e.ill});
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic stim_t S(input bit rst, input bit ld_n, input bit en_n, input bit dir,
                                input int typ, input int lv, input int lim, input bit wr);
        stim_t s;
        s.rst = rst; s.ld_n = ld_n; s.en_n = en_n; s.dir = dir;
        s.typ = 3'(typ); s.lv = 8'(lv); s.lim = 8'(lim); s.wr = wr;
        return s;
    endfunction

    function automatic stim_t rnd(input int w);
        stim_t s;
        int full, typ, d, maxdec;
        full   = msk(w);
        maxdec = (w == 8) ? 99 : 9;
        typ    = int'($urandom_range(0, 7));
        s.rst  = ($urandom_range(0, 63) == 0);
        s.ld_n = ($urandom_range(0, 9) != 0);
        s.en_n = ($urandom_range(0, 3) == 0);
        s.dir  = 1'($urandom_range(0, 1));
        s.typ  = 3'(typ);
        s.wr   = 1'($urandom_range(0, 1));
        s.lv   = 8'($urandom & 32'(full));
        s.lim  = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15) & 32'(full)) : 8'($urandom & 32'(full));
        if ($urandom_range(0, 1) != 0) begin
            case (typ)
                2: s.lv = 8'(1 << $urandom_range(0, w - 1));
                3: begin
                    d    = int'($urandom_range(0, w));
                    s.lv = 8'(($urandom_range(0, 1) != 0) ? msk(d) : ((full << (w - d)) & full));
                end
                4: s.lv = 8'(to_bcd(int'($urandom_range(0, maxdec)), w));
                default: ;
            endcase
        end
        if (typ == 4) s.lim = 8'(to_bcd(int'($urandom_range(0, maxdec)), w));
        return s;
    endfunction

    task automatic drive(input stim_t s0, input stim_t s1);
        exp_t e0, e1;
        @(negedge clk);
        rst0 = s0.rst; ld0_n = s0.ld_n; en0_n = s0.en_n; dir0 = s0.dir;
        typ0 = s0.typ; lv0 = s0.lv; lim0 = s0.lim; wr0 = s0.wr;
        rst1 = s1.rst; ld1_n = s1.ld_n; en1_n = s1.en_n; dir1 = s1.dir;
        typ1 = s1.typ; lv1 = s1.lv[3:0]; lim1 = s1.lim[3:0]; wr1 = s1.wr;
        model(0, s0, e0);
        model(1, s1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    initial begin
        stim_t idle, up, dn, rst;
        idle = S(0, 1, 1, 0, 0, 0, 0, 0);
        up   = S(0, 1, 0, 1, 0, 0, 0, 0);
        dn   = S(0, 1, 0, 0, 0, 0, 0, 0);
        rst  = S(1, 1, 1, 0, 0, 0, 0, 0);

        drive(rst, rst);
        drive(idle, idle);

        drive(S(0, 0, 1, 1, 0, 7, 9, 0), idle);
        repeat (4) drive(up, idle);

        drive(S(0, 0, 1, 0, 0, 2, 255, 1), idle);
        repeat (4) drive(dn, idle);
        drive(idle, idle);

        drive(S(0, 0, 1, 1, 1, 8'h80, 0, 0), idle);
        repeat (2) drive(up, idle);
        drive(S(0, 0, 1, 0, 1, 8'h00, 0, 0), idle);
        drive(dn, idle);

        drive(S(0, 0, 1, 1, 4, 8'h98, 8'h99, 0), idle);
        repeat (3) drive(up, idle);
        drive(S(0, 0, 1, 1, 4, 8'h1A, 8'h99, 0), idle);
        drive(idle, idle);
        drive(up, idle);
        drive(S(0, 0, 1, 0, 4, 8'h1A, 8'h99, 1), idle);
        drive(dn, idle);

        drive(idle, S(0, 0, 1, 1, 3, 0, 0, 0));
        repeat (8) drive(idle, up);
        drive(idle, S(0, 0, 1, 1, 2, 4'b0011, 0, 0));
        drive(idle, up);
        drive(idle, S(0, 0, 1, 0, 2, 4'b1000, 0, 0));
        repeat (2) drive(idle, dn);

        drive(S(0, 0, 1, 1, 0, 0, 255, 0), idle);
        repeat (3) drive(up, idle);
        drive(S(1, 0, 0, 1, 2, 8'h55, 8'h10, 1), idle);
        repeat (3) drive(up, idle);

        repeat (3000) drive(rnd(8), rnd(4));
        drive(idle, idle);

        @(posedge clk);
        #2;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard.drain: got %0d entries left, expected 0", q0.size() + q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
